seg7_multi_display: RTL and testbench
=====================================

Name: seg7_multi_display

Overview:
Parametrised multi-digit hex 7-segment driver; successor to the two-digit combinational decoder.
- Latches an NDIG-nibble value on a load strobe.
- Adds per-digit blink, leading-zero suppression and a global enable.
- Drives active-low segment buses for the board's static digits. Optionally also drives a time-multiplexed scan bus.
- Sits between display producers (keyboard scan-code/ASCII/count logic) and the top-level digit pins.

Parameters:
NDIG, 8, number of hex digits (1..8); digit 0 = least significant nibble.
BLINK_DIV, 25000000, clock cycles per blink half-period (>=2).
SCAN_DIV, 50000, clock cycles each digit is held in scan mode (>=1; used only with SEG7_SCAN_EN).

Ports:
clk  in  1  system clock, all logic rising-edge.
clrn  in  1  synchronous active-low reset.
data  in  4*NDIG  hex value, digit i = data[4i+3:4i].
load  in  1  capture data into the display register this cycle.
en  in  1  global display enable; 0 blanks all digits.
lz_en  in  1  1 = suppress leading zeros.
blink_mask  in  NDIG  bit i = 1 makes digit i blink.
seg  out  7*NDIG  static segments, digit i = seg[7i+6:7i], bit order a..g = bit6..bit0, active-low.
ack  out  1  one-cycle pulse, the cycle after a load is captured.

Behaviour:
- Reset (clrn=0 at a rising edge), applied regardless of load:
  - data_q=0, blink counter=0, blink phase=1 (visible), ack=0.
  - All seg bits = 1 (blank).
  - Scan state is cleared (see Optional Feature).
- Load:
  - load=1 at edge N: data_q<=data at N; ack=1 for edge N+1 only.
  - Back-to-back loads each capture their own value and each produce an ack; ack stays high across consecutive loads.
- Glyphs (active-low, a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
  - blank=1111111.
- Blink counter:
  - Counts 0..BLINK_DIV-1 and wraps.
  - At each wrap, phase toggles.
  - Runs continuously, independent of en and load.
- Per-digit visible condition: en=1 AND NOT (blink_mask[i]=1 AND phase=0) AND NOT suppressed[i].
- Leading-zero suppression (lz_en=1):
  - Digit i is suppressed if digits NDIG-1..i of data_q are all zero and i>0.
  - Digit 0 is never suppressed, so a value of 0 shows a single "0".
  - lz_en=0 means no digit is suppressed.
  - Suppression is evaluated on data_q, not on data.
- Output timing:
  - seg is registered; it reflects data_q, en, lz_en, blink_mask and phase from the previous cycle.
  - Load at edge N gives the new glyphs on seg after edge N+1 (2-edge latency from load).
  - en, lz_en and blink_mask take effect 1 edge after sampling.
- Boundaries:
  - A blink-phase toggle in the same cycle as a load applies both, each on its own path.
  - Reset mid-blink restarts the blink at phase=1 and count 0.
  - NDIG=1: lz_en has no effect.

Optional Feature:
Macro SEG7_SCAN_EN.
- Defined:
  - Adds outputs seg_mux (out, 7, active-low) and an (out, NDIG, active-low one-hot digit select).
  - A scan counter (0..SCAN_DIV-1) advances the digit index 0,1,..,NDIG-1,0 each wrap.
  - seg_mux/an are registered: an has bit idx low; seg_mux = seg slice for idx.
  - Reset: idx=0, scan counter=0, an=all 1, seg_mux=all 1.
  - After reset, the first valid an appears after the first registered update.
  - The static seg output is unchanged by this macro.
- Undefined: these ports and the scan logic do not exist; the module is static only.

Test Plan:
1. NDIG=8, reset then idle -> seg=all 1s, ack=0; hold clrn=0 with load=1 -> data_q stays 0 and ack stays 0.
2. load=1 with data=32'h0123_ABCD, lz_en=0, en=1 -> ack high 1 cycle. Two edges after load: digit0=1000010 (d), digit3=0001000 (A), digit7=0000001 (0).
3. Same value, lz_en=1 -> digit7 blank, digit6=1001111; data=0 -> digits 7..1 blank, digit0=0000001.
4. BLINK_DIV=4, blink_mask=8'h01, data=0x5 -> digit0 alternates 0100100 / 1111111 every 4 cycles; other digits steady; en=0 -> all blank next cycle.
5. Consecutive loads of 0x11, 0x22, 0x33 on 3 cycles -> ack high 3 cycles; seg ends showing 33 with no dropped value.
6. SEG7_SCAN_EN, NDIG=4, SCAN_DIV=2 -> an sequence 1110, 1101, 1011, 0111 repeating every 2 cycles, with seg_mux matching each digit's seg slice.

Source files
------------

// File: rtl/seg7_multi_display.sv
// Multi-digit hex 7-segment driver: latched value, per-digit blink, leading-zero
// suppression, global enable. Define SEG7_SCAN_EN to add the multiplexed scan bus.
module seg7_multi_display #(
    parameter int NDIG      = 8,
    parameter int BLINK_DIV = 25000000,
    parameter int SCAN_DIV  = 50000
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [4*NDIG-1:0] data,
    input  logic              load,
    input  logic              en,
    input  logic              lz_en,
    input  logic [NDIG-1:0]   blink_mask,
    output logic [7*NDIG-1:0] seg,
    output logic              ack
`ifdef SEG7_SCAN_EN
    ,
    output logic [6:0]        seg_mux,
    output logic [NDIG-1:0]   an
`endif
);

    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_glyph = 7'b0000001;
            4'h1:    hex_glyph = 7'b1001111;
            4'h2:    hex_glyph = 7'b0010010;
            4'h3:    hex_glyph = 7'b0000110;
            4'h4:    hex_glyph = 7'b1001100;
            4'h5:    hex_glyph = 7'b0100100;
            4'h6:    hex_glyph = 7'b0100000;
            4'h7:    hex_glyph = 7'b0001111;
            4'h8:    hex_glyph = 7'b0000000;
            4'h9:    hex_glyph = 7'b0000100;
            4'hA:    hex_glyph = 7'b0001000;
            4'hB:    hex_glyph = 7'b1100000;
            4'hC:    hex_glyph = 7'b0110001;
            4'hD:    hex_glyph = 7'b1000010;
            4'hE:    hex_glyph = 7'b0110000;
            4'hF:    hex_glyph = 7'b0111000;
            default: hex_glyph = 7'b1111111;
        endcase
    endfunction

    logic [4*NDIG-1:0] data_q, data_d;
    logic [7*NDIG-1:0] seg_q, seg_d;
    logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
    logic              phase_q, phase_d;
    logic              ack_q, ack_d;
    logic              all_zero_s;
    logic [NDIG-1:0]   sup_s;
    logic [NDIG-1:0]   vis_s;

    // Next-state for the value register, ack pulse and blink timebase
    always_comb begin
        if (load) begin
            data_d = data;
        end else begin
            data_d = data_q;
        end
        ack_d = load;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = {BW{1'b0}};
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
            phase_d     = phase_q;
        end
    end

    // Glyph selection; the zero scan runs from the top digit so suppression stops at the first non-zero
    always_comb begin
        all_zero_s = 1'b1;
        sup_s      = {NDIG{1'b0}};
        vis_s      = {NDIG{1'b0}};
        seg_d      = {(7*NDIG){1'b1}};
        for (int i = NDIG - 1; i >= 0; i--) begin
            all_zero_s = all_zero_s & (data_q[4*i +: 4] == 4'h0);
            sup_s[i]   = lz_en & all_zero_s & (i != 0);
            vis_s[i]   = en & ~(blink_mask[i] & ~phase_q) & ~sup_s[i];
            if (vis_s[i]) begin
                seg_d[7*i +: 7] = hex_glyph(data_q[4*i +: 4]);
            end else begin
                seg_d[7*i +: 7] = 7'b1111111;
            end
        end
    end

    // Static display state registers
    always_ff @(posedge clk) begin
        if (!clrn) begin
            data_q      <= {(4*NDIG){1'b0}};
            seg_q       <= {(7*NDIG){1'b1}};
            blink_cnt_q <= {BW{1'b0}};
            phase_q     <= 1'b1;
            ack_q       <= 1'b0;
        end else begin
            data_q      <= data_d;
            seg_q       <= seg_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            ack_q       <= ack_d;
        end
    end

    assign seg = seg_q;
    assign ack = ack_q;

`ifdef SEG7_SCAN_EN
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

    logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [NDIG-1:0] an_q, an_d;
    logic [6:0]      seg_mux_q, seg_mux_d;

    // Scan timebase and digit index; an/seg_mux are both taken from idx_q so they stay aligned
    always_comb begin
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = {SW{1'b0}};
            if (idx_q == IDX_LAST) begin
                idx_d = {IW{1'b0}};
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end else begin
            scan_cnt_d = scan_cnt_q + SW'(1);
            idx_d      = idx_q;
        end
        an_d      = ~(NDIG'(1) << idx_q);
        seg_mux_d = seg_q[7*int'(idx_q) +: 7];
    end

    // Scan bus registers
    always_ff @(posedge clk) begin
        if (!clrn) begin
            scan_cnt_q <= {SW{1'b0}};
            idx_q      <= {IW{1'b0}};
            an_q       <= {NDIG{1'b1}};
            seg_mux_q  <= 7'b1111111;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_mux_q  <= seg_mux_d;
        end
    end

    assign an      = an_q;
    assign seg_mux = seg_mux_q;
`endif

endmodule

// File: tb/tb_seg7_multi_display.sv
// Directed self-checking bench for seg7_multi_display (NDIG=8, short blink period);
// with SEG7_SCAN_EN a second NDIG=4 instance exercises the scan bus.
module tb_seg7_multi_display;

    localparam logic [6:0] BLANK = 7'b1111111;

    logic        clk = 1'b0;
    logic        clrn;
    logic [31:0] data;
    logic        load;
    logic        en;
    logic        lz_en;
    logic [7:0]  blink_mask;
    logic [55:0] seg;
    logic        ack;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

`ifdef SEG7_SCAN_EN
    logic [6:0]  seg_mux;
    logic [7:0]  an;
    logic [27:0] seg4;
    logic        ack4;
    logic [6:0]  seg_mux4;
    logic [3:0]  an4;

    seg7_multi_display #(.NDIG(8), .BLINK_DIV(4), .SCAN_DIV(2)) dut (
        .clk(clk), .clrn(clrn), .data(data), .load(load), .en(en),
        .lz_en(lz_en), .blink_mask(blink_mask), .seg(seg), .ack(ack),
        .seg_mux(seg_mux), .an(an)
    );

    seg7_multi_display #(.NDIG(4), .BLINK_DIV(4), .SCAN_DIV(2)) dut4 (
        .clk(clk), .clrn(clrn), .data(data[15:0]), .load(load), .en(en),
        .lz_en(lz_en), .blink_mask(blink_mask[3:0]), .seg(seg4), .ack(ack4),
        .seg_mux(seg_mux4), .an(an4)
    );
`else
    seg7_multi_display #(.NDIG(8), .BLINK_DIV(4), .SCAN_DIV(2)) dut (
        .clk(clk), .clrn(clrn), .data(data), .load(load), .en(en),
        .lz_en(lz_en), .blink_mask(blink_mask), .seg(seg), .ack(ack)
    );
`endif

    function automatic logic [6:0] dig(input int i);
        dig = seg[7*i +: 7];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clrn = 1'b0; load = 1'b1; data = 32'hFFFF_FFFF;
        en = 1'b1; lz_en = 1'b0; blink_mask = 8'h00;
        tick(); tick();
        total_cnt++;
        if (seg !== {56{1'b1}}) $display("FAIL reset_seg: got %h expected %h", seg, {56{1'b1}});
        else pass_cnt++;
        total_cnt++;
        if (ack !== 1'b0) $display("FAIL reset_ack: got %b expected 0", ack);
        else pass_cnt++;
        clrn = 1'b1; load = 1'b0;
        tick();
        total_cnt++;
        if (seg !== {8{7'b0000001}}) $display("FAIL reset_data_zero: got %h expected %h", seg, {8{7'b0000001}});
        else pass_cnt++;
        total_cnt++;
        if (ack !== 1'b0) $display("FAIL reset_release_ack: got %b expected 0", ack);
        else pass_cnt++;
    endtask

    task automatic test_load_decode();
        data = 32'h0123_ABCD; load = 1'b1; en = 1'b1; lz_en = 1'b0;
        tick();
        load = 1'b0;
        total_cnt++;
        if (ack !== 1'b1) $display("FAIL load_ack_high: got %b expected 1", ack);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (ack !== 1'b0) $display("FAIL load_ack_low: got %b expected 0", ack);
        else pass_cnt++;
        total_cnt++;
        if (dig(0) !== 7'b1000010) $display("FAIL dec_d0: got %b expected 1000010", dig(0));
        else pass_cnt++;
        total_cnt++;
        if (dig(1) !== 7'b0110001) $display("FAIL dec_d1: got %b expected 0110001", dig(1));
        else pass_cnt++;
        total_cnt++;
        if (dig(2) !== 7'b1100000) $display("FAIL dec_d2: got %b expected 1100000", dig(2));
        else pass_cnt++;
        total_cnt++;
        if (dig(3) !== 7'b0001000) $display("FAIL dec_d3: got %b expected 0001000", dig(3));
        else pass_cnt++;
        total_cnt++;
        if (dig(7) !== 7'b0000001) $display("FAIL dec_d7: got %b expected 0000001", dig(7));
        else pass_cnt++;
    endtask

    task automatic test_lz();
        lz_en = 1'b1;
        tick();
        total_cnt++;
        if (dig(7) !== BLANK) $display("FAIL lz_d7_blank: got %b expected %b", dig(7), BLANK);
        else pass_cnt++;
        total_cnt++;
        if (dig(6) !== 7'b1001111) $display("FAIL lz_d6: got %b expected 1001111", dig(6));
        else pass_cnt++;
        total_cnt++;
        if (dig(0) !== 7'b1000010) $display("FAIL lz_d0: got %b expected 1000010", dig(0));
        else pass_cnt++;
        data = 32'h0000_0000; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        total_cnt++;
        if (seg !== {{7{BLANK}}, 7'b0000001})
            $display("FAIL lz_zero: got %h expected %h", seg, {{7{BLANK}}, 7'b0000001});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        for (int k = 0; k < 3; k++) begin
            data = {24'h0, vals[k]}; load = 1'b1;
            tick();
            total_cnt++;
            if (ack !== 1'b1) $display("FAIL b2b_ack_%0d: got %b expected 1", k, ack);
            else pass_cnt++;
        end
        total_cnt++;
        if (seg !== {{6{BLANK}}, 7'b0010010, 7'b0010010})
            $display("FAIL b2b_mid22: got %h expected %h", seg, {{6{BLANK}}, 7'b0010010, 7'b0010010});
        else pass_cnt++;
        load = 1'b0;
        tick();
        total_cnt++;
        if (ack !== 1'b0) $display("FAIL b2b_ack_end: got %b expected 0", ack);
        else pass_cnt++;
        total_cnt++;
        if (seg !== {{6{BLANK}}, 7'b0000110, 7'b0000110})
            $display("FAIL b2b_final33: got %h expected %h", seg, {{6{BLANK}}, 7'b0000110, 7'b0000110});
        else pass_cnt++;
    endtask

    task automatic test_blink();
        logic [6:0] exp0;
        clrn = 1'b0; load = 1'b0;
        tick();
        clrn = 1'b1; data = 32'h0000_0005; load = 1'b1;
        blink_mask = 8'h01; en = 1'b1; lz_en = 1'b0;
        tick();
        load = 1'b0;
        // phase after edge j (from reset) is visible for j/4 even
        for (int k = 2; k <= 13; k++) begin
            tick();
            exp0 = (((k - 1) / 4) % 2 == 0) ? 7'b0100100 : BLANK;
            total_cnt++;
            if (dig(0) !== exp0) $display("FAIL blink_d0_k%0d: got %b expected %b", k, dig(0), exp0);
            else pass_cnt++;
            total_cnt++;
            if (dig(1) !== 7'b0000001) $display("FAIL blink_d1_k%0d: got %b expected 0000001", k, dig(1));
            else pass_cnt++;
        end
        en = 1'b0;
        tick();
        total_cnt++;
        if (seg !== {56{1'b1}}) $display("FAIL en_off_blank: got %h expected %h", seg, {56{1'b1}});
        else pass_cnt++;
        en = 1'b1; blink_mask = 8'h00;
    endtask

`ifdef SEG7_SCAN_EN
    task automatic test_scan();
        logic [6:0] exp_g [4];
        logic [3:0] exp_an;
        int idx;
        exp_g[0] = 7'b1001111; exp_g[1] = 7'b0010010;
        exp_g[2] = 7'b0000110; exp_g[3] = 7'b1001100;
        clrn = 1'b0; load = 1'b0;
        tick();
        total_cnt++;
        if (an4 !== 4'hF) $display("FAIL scan_reset_an: got %b expected 1111", an4);
        else pass_cnt++;
        total_cnt++;
        if (seg_mux4 !== BLANK) $display("FAIL scan_reset_mux: got %b expected %b", seg_mux4, BLANK);
        else pass_cnt++;
        clrn = 1'b1; data = 32'h0000_4321; load = 1'b1;
        en = 1'b1; lz_en = 1'b0; blink_mask = 8'h00;
        tick();
        load = 1'b0;
        for (int k = 2; k <= 11; k++) begin
            tick();
            idx = ((k - 1) / 2) % 4;
            exp_an = ~(4'b0001 << idx);
            total_cnt++;
            if (an4 !== exp_an) $display("FAIL scan_an_k%0d: got %b expected %b", k, an4, exp_an);
            else pass_cnt++;
            if (k >= 3) begin
                total_cnt++;
                if (seg_mux4 !== exp_g[idx])
                    $display("FAIL scan_mux_k%0d: got %b expected %b", k, seg_mux4, exp_g[idx]);
                else pass_cnt++;
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_decode();
        test_lz();
        test_back_to_back();
        test_blink();
`ifdef SEG7_SCAN_EN
        test_scan();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
